// File: rtl/pkt_pkg.sv
// Shared command constants, error codes and FSM state type for the packet command decoder.
package pkt_pkg;

  localparam logic [7:0] CMD_CSR      = 8'h00;
  localparam logic [7:0] CMD_BUF_BASE = 8'h20;
  localparam logic [7:0] CMD_START    = 8'h50;
  localparam logic [7:0] CMD_STATUS   = 8'h70;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BADCMD  = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {S_CMD, S_ADDR, S_DATA, S_CSUM, S_DISP} state_t;

  typedef enum logic [2:0] {K_CSR, K_BUF, K_START, K_STATUS, K_ILLEGAL} cmd_kind_t;

  // Start/status take precedence over a buffer code that aliases them when many buffers exist.
  function automatic cmd_kind_t cmd_kind(input logic [7:0] cmd, input int unsigned num_buf);
    cmd_kind_t k;
    k = K_ILLEGAL;
    if (cmd == CMD_CSR) k = K_CSR;
    else if (cmd == CMD_START) k = K_START;
    else if (cmd == CMD_STATUS) k = K_STATUS;
    else if (cmd[3:0] == 4'h0 && cmd >= CMD_BUF_BASE && {28'd0, cmd[7:4]} < num_buf + 32'd2)
      k = K_BUF;
    return k;
  endfunction

endpackage

// File: rtl/pkt_timeout_ctr.sv
// Idle-cycle counter; o_expire flags the idle cycle whose count reaches TIMEOUT_CYC.
module pkt_timeout_ctr #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr || !i_en) r_cnt <= '0;
    else if (r_cnt != LAST) r_cnt <= r_cnt + CW'(1);
  end

  assign o_expire = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/pkt_cmd_decoder.sv
// Byte-stream packet decoder: frames cmd/addr/data(/checksum) and dispatches one strobe per packet.
module pkt_cmd_decoder
  import pkt_pkg::*;
#(
  parameter int DATA_BYTES  = 4,
  parameter int ADDR_BYTES  = 2,
  parameter int NUM_BUF     = 2,
  parameter int CSUM_EN     = 0,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  input  logic                    dsp_ready,
  output logic                    csr_we,
  output logic [NUM_BUF-1:0]      buf_we,
  output logic                    start_pulse,
  output logic                    status_req,
  output logic [8*ADDR_BYTES-1:0] addr,
  output logic [8*DATA_BYTES-1:0] wdata,
  output logic                    busy,
  output logic                    err_pulse,
  output logic [1:0]              err_code,
  output logic [15:0]             pkt_cnt,
  output logic [7:0]              err_cnt
);

  localparam logic [3:0] ADDR_LAST = 4'(ADDR_BYTES - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BYTES - 1);

  state_t                  r_state;
  logic [3:0]              r_bcnt;
  logic [7:0]              r_cmd;
  logic [7:0]              r_xor;
  logic [8*ADDR_BYTES-1:0] r_addr;
  logic [8*DATA_BYTES-1:0] r_wdata;
  logic                    r_csr_we;
  logic [NUM_BUF-1:0]      r_buf_we;
  logic                    r_start;
  logic                    r_status;
  logic                    r_err_pulse;
  err_code_t               r_err_code;
  logic [15:0]             r_pkt_cnt;
  logic [7:0]              r_err_cnt;

  logic      w_accept;
  logic      w_tmo_en;
  logic      w_expire;
  logic      w_finish;
  logic      w_err;
  logic      w_dispatch;
  err_code_t w_err_code;
  cmd_kind_t w_kind;
  logic [3:0] w_bidx;

  assign in_ready    = (r_state != S_DISP);
  assign busy        = (r_state != S_CMD);
  assign w_accept    = in_valid && in_ready;
  assign w_tmo_en    = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_kind      = cmd_kind(r_cmd, unsigned'(NUM_BUF));
  assign w_bidx      = r_cmd[7:4] - 4'd2;
  assign w_dispatch  = w_finish && !w_err;

  assign csr_we      = r_csr_we;
  assign buf_we      = r_buf_we;
  assign start_pulse = r_start;
  assign status_req  = r_status;
  assign addr        = r_addr;
  assign wdata       = r_wdata;
  assign err_pulse   = r_err_pulse;
  assign err_code    = r_err_code;
  assign pkt_cnt     = r_pkt_cnt;
  assign err_cnt     = r_err_cnt;

  pkt_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_accept),
    .i_en     (w_tmo_en),
    .o_expire (w_expire)
  );

  // The final byte decides dispatch; a bad command outranks a bad checksum.
  always_comb begin
    w_finish   = 1'b0;
    w_err      = 1'b0;
    w_err_code = ERR_NONE;
    if (w_accept) begin
      if (r_state == S_CSUM) w_finish = 1'b1;
      else if (r_state == S_DATA && r_bcnt == DATA_LAST && CSUM_EN == 0) w_finish = 1'b1;
    end
    if (w_expire) begin
      w_err      = 1'b1;
      w_err_code = ERR_TIMEOUT;
    end else if (w_finish && w_kind == K_ILLEGAL) begin
      w_err      = 1'b1;
      w_err_code = ERR_BADCMD;
    end else if (w_finish && r_state == S_CSUM && (r_xor ^ in_data) != 8'h00) begin
      w_err      = 1'b1;
      w_err_code = ERR_CSUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_CMD;
      r_bcnt      <= '0;
      r_cmd       <= '0;
      r_xor       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_err_pulse <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= w_err;
      if (w_err) begin
        r_err_code <= w_err_code;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
      case (r_state)
        S_CMD: if (w_accept) begin
          r_cmd   <= in_data;
          r_xor   <= in_data;
          r_bcnt  <= '0;
          r_state <= S_ADDR;
        end
        S_ADDR: if (w_accept) begin
          r_addr[8*r_bcnt[1:0] +: 8] <= in_data;
          r_xor <= r_xor ^ in_data;
          if (r_bcnt == ADDR_LAST) begin
            r_bcnt  <= '0;
            r_state <= S_DATA;
          end else r_bcnt <= r_bcnt + 4'd1;
        end else if (w_expire) begin
          r_bcnt  <= '0;
          r_state <= S_CMD;
        end
        S_DATA: if (w_accept) begin
          r_wdata[8*r_bcnt[2:0] +: 8] <= in_data;
          r_xor <= r_xor ^ in_data;
          if (r_bcnt == DATA_LAST) begin
            r_bcnt  <= '0;
            r_state <= (CSUM_EN != 0) ? S_CSUM : (w_dispatch ? S_DISP : S_CMD);
          end else r_bcnt <= r_bcnt + 4'd1;
        end else if (w_expire) begin
          r_bcnt  <= '0;
          r_state <= S_CMD;
        end
        S_CSUM: if (w_accept || w_expire) begin
          r_bcnt  <= '0;
          r_state <= w_dispatch ? S_DISP : S_CMD;
        end
        S_DISP: if (dsp_ready) r_state <= S_CMD;
        default: r_state <= S_CMD;
      endcase
    end
  end

  // Strobes rise on entry to S_DISP and hold until the sink takes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_csr_we  <= 1'b0;
      r_buf_we  <= '0;
      r_start   <= 1'b0;
      r_status  <= 1'b0;
      r_pkt_cnt <= '0;
    end else if (w_dispatch) begin
      r_csr_we <= (w_kind == K_CSR);
      r_buf_we <= (w_kind == K_BUF) ? (NUM_BUF'(1) << w_bidx) : '0;
      r_start  <= (w_kind == K_START);
      r_status <= (w_kind == K_STATUS);
    end else if (r_state == S_DISP && dsp_ready) begin
      r_csr_we  <= 1'b0;
      r_buf_we  <= '0;
      r_start   <= 1'b0;
      r_status  <= 1'b0;
      r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pkt_cmd_decoder.sv
// Randomized bench for pkt_cmd_decoder: two configurations driven against a packet-level reference model.
module tb_pkt_cmd_decoder;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic rst;
  logic inValid;
  logic [7:0] inData;
  logic dspReady;
  logic sel;

  logic ready0, csr0, start0, status0, busy0, errp0;
  logic [1:0] buf0, errc0;
  logic [15:0] addr0, pkt0;
  logic [31:0] wd0;
  logic [7:0] errcnt0;

  logic ready1, csr1, start1, status1, busy1, errp1;
  logic [1:0] buf1, errc1;
  logic [15:0] addr1, pkt1;
  logic [63:0] wd1;
  logic [7:0] errcnt1;

  logic obsReady, obsBusy, obsErrPulse;
  logic [1:0] obsErrCode;
  logic [4:0] obsStrobe;
  logic [15:0] obsAddr, obsPkt;
  logic [63:0] obsData;
  logic [7:0] obsErrCnt;

  int checks = 0;
  int errors = 0;
  int pktCnt[2];
  int errCnt[2];

  always #5 clk = ~clk;

  pkt_cmd_decoder #(.DATA_BYTES(4), .ADDR_BYTES(2), .NUM_BUF(2), .CSUM_EN(0), .TIMEOUT_CYC(100)) dut0 (
    .clk(clk), .rst(rst), .in_valid(inValid && !sel), .in_data(inData), .in_ready(ready0),
    .dsp_ready(dspReady), .csr_we(csr0), .buf_we(buf0), .start_pulse(start0), .status_req(status0),
    .addr(addr0), .wdata(wd0), .busy(busy0), .err_pulse(errp0), .err_code(errc0),
    .pkt_cnt(pkt0), .err_cnt(errcnt0));

  pkt_cmd_decoder #(.DATA_BYTES(8), .ADDR_BYTES(2), .NUM_BUF(2), .CSUM_EN(1), .TIMEOUT_CYC(100)) dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid && sel), .in_data(inData), .in_ready(ready1),
    .dsp_ready(dspReady), .csr_we(csr1), .buf_we(buf1), .start_pulse(start1), .status_req(status1),
    .addr(addr1), .wdata(wd1), .busy(busy1), .err_pulse(errp1), .err_code(errc1),
    .pkt_cnt(pkt1), .err_cnt(errcnt1));

  always_comb begin
    if (sel) begin
      obsReady = ready1; obsBusy = busy1; obsErrPulse = errp1; obsErrCode = errc1;
      obsStrobe = {status1, start1, buf1, csr1}; obsAddr = addr1; obsData = wd1;
      obsPkt = pkt1; obsErrCnt = errcnt1;
    end else begin
      obsReady = ready0; obsBusy = busy0; obsErrPulse = errp0; obsErrCode = errc0;
      obsStrobe = {status0, start0, buf0, csr0}; obsAddr = addr0; obsData = {32'd0, wd0};
      obsPkt = pkt0; obsErrCnt = errcnt0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Strobe packing {status, start, buf[1], buf[0], csr}; zero means the command is illegal.
  function automatic logic [4:0] modelStrobe(input logic [7:0] cmd);
    logic [4:0] s;
    s = 5'd0;
    if (cmd == 8'h00) s = 5'b00001;
    else if (cmd == 8'h50) s = 5'b01000;
    else if (cmd == 8'h70) s = 5'b10000;
    else for (int c = 0; c < 2; c++) if (int'(cmd) == 32 + 16 * c) s = 5'(2 << c);
    return s;
  endfunction

  function automatic byte_q_t buildPacket(input logic [7:0] cmd, input logic [15:0] ad,
                                          input logic [63:0] data, input bit badCsum);
    byte_q_t q;
    logic [7:0] x;
    q.push_back(cmd);
    q.push_back(ad[7:0]);
    q.push_back(ad[15:8]);
    for (int i = 0; i < (sel ? 8 : 4); i++) q.push_back(data[8*i +: 8]);
    if (sel) begin
      x = 8'h00;
      foreach (q[i]) x = x ^ q[i];
      q.push_back(badCsum ? (x ^ 8'hA5) : x);
    end
    return q;
  endfunction

  task automatic sendBytes(input byte_q_t q, input bit gaps);
    for (int i = 0; i < q.size(); i++) begin
      inValid = 1'b0;
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      inValid = 1'b1;
      inData  = q[i];
      @(posedge clk); #1;
    end
    inValid = 1'b0;
  endtask

  task automatic checkDispatch(input string tag, input logic [4:0] expStb, input logic [15:0] expAddr,
                               input logic [63:0] expData, input int delay);
    for (int k = 0; k <= delay; k++) begin
      dspReady = (k == delay);
      checkOutput({tag, "_stb"}, 64'(obsStrobe), 64'(expStb));
      checkOutput({tag, "_addr"}, 64'(obsAddr), 64'(expAddr));
      checkOutput({tag, "_data"}, obsData, expData);
      checkOutput({tag, "_rdy_lo"}, 64'(obsReady), 64'd0);
      @(posedge clk); #1;
    end
    dspReady = 1'b0;
    pktCnt[sel] = (pktCnt[sel] + 1) % 65536;
    checkOutput({tag, "_stb_off"}, 64'(obsStrobe), 64'd0);
    checkOutput({tag, "_idle"}, 64'(obsBusy), 64'd0);
    checkOutput({tag, "_pktcnt"}, 64'(obsPkt), 64'(pktCnt[sel]));
  endtask

  task automatic checkError(input string tag, input logic [1:0] code);
    errCnt[sel] = (errCnt[sel] < 255) ? errCnt[sel] + 1 : 255;
    checkOutput({tag, "_errp"}, 64'(obsErrPulse), 64'd1);
    checkOutput({tag, "_code"}, 64'(obsErrCode), 64'(code));
    checkOutput({tag, "_nostb"}, 64'(obsStrobe), 64'd0);
    checkOutput({tag, "_idle"}, 64'(obsBusy), 64'd0);
    checkOutput({tag, "_errcnt"}, 64'(obsErrCnt), 64'(errCnt[sel]));
    @(posedge clk); #1;
    checkOutput({tag, "_errp_one"}, 64'(obsErrPulse), 64'd0);
    checkOutput({tag, "_code_held"}, 64'(obsErrCode), 64'(code));
    checkOutput({tag, "_nostb2"}, 64'(obsStrobe), 64'd0);
    checkOutput({tag, "_pkt_same"}, 64'(obsPkt), 64'(pktCnt[sel]));
  endtask

  task automatic applyStimulus(input string tag, input logic [7:0] cmd, input logic [15:0] ad,
                               input logic [63:0] data, input bit badCsum, input int delay, input bit gaps);
    byte_q_t q;
    logic [63:0] expData;
    logic [4:0] expStb;
    expData = sel ? data : {32'd0, data[31:0]};
    expStb  = modelStrobe(cmd);
    q = buildPacket(cmd, ad, data, badCsum);
    sendBytes(q, gaps);
    if (expStb == 5'd0) checkError(tag, 2'd1);
    else if (badCsum) checkError(tag, 2'd2);
    else checkDispatch(tag, expStb, ad, expData, delay);
  endtask

  // Three bytes then silence; optionally a fourth byte lands on the 100th idle cycle.
  task automatic timeoutCase(input string tag, input bit rescue);
    byte_q_t q, head, rest;
    bit seen;
    int firstAt;
    q = buildPacket(8'h00, 16'h1234, 64'h0000_0000_CAFE_F00D, 1'b0);
    for (int i = 0; i < 3; i++) head.push_back(q[i]);
    for (int i = 4; i < q.size(); i++) rest.push_back(q[i]);
    sendBytes(head, 1'b0);
    seen = 1'b0;
    firstAt = 0;
    for (int k = 1; k <= (rescue ? 99 : 100); k++) begin
      @(posedge clk); #1;
      if (obsErrPulse && !seen) begin seen = 1'b1; firstAt = k; end
    end
    if (!rescue) begin
      checkOutput({tag, "_latency"}, 64'(firstAt), 64'd100);
      checkError(tag, 2'd3);
    end else begin
      checkOutput({tag, "_early"}, 64'(seen), 64'd0);
      inValid = 1'b1;
      inData  = q[3];
      @(posedge clk); #1;
      inValid = 1'b0;
      checkOutput({tag, "_noerr"}, 64'(obsErrPulse), 64'd0);
      checkOutput({tag, "_busy"}, 64'(obsBusy), 64'd1);
      sendBytes(rest, 1'b0);
      checkDispatch(tag, 5'b00001, 16'h1234, 64'h0000_0000_CAFE_F00D, 0);
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pktCnt[0] = 0; pktCnt[1] = 0;
    errCnt[0] = 0; errCnt[1] = 0;
  endtask

  initial begin
    byte_q_t q, part;
    logic [7:0] cmd;
    logic [4:0] stb;
    bit bad;
    rst = 1'b1; inValid = 1'b0; inData = 8'h00; dspReady = 1'b0; sel = 1'b0;
    pktCnt[0] = 0; pktCnt[1] = 0; errCnt[0] = 0; errCnt[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_ready", 64'(obsReady), 64'd1);
    checkOutput("rst_busy", 64'(obsBusy), 64'd0);
    checkOutput("rst_stb", 64'(obsStrobe), 64'd0);
    checkOutput("rst_addr", 64'(obsAddr), 64'd0);
    checkOutput("rst_data", obsData, 64'd0);
    checkOutput("rst_errp", 64'(obsErrPulse), 64'd0);
    checkOutput("rst_code", 64'(obsErrCode), 64'd0);
    checkOutput("rst_pkt", 64'(obsPkt), 64'd0);
    checkOutput("rst_errcnt", 64'(obsErrCnt), 64'd0);

    applyStimulus("csr", 8'h00, 16'h0008, 64'h8, 1'b0, 0, 1'b0);
    applyStimulus("start_bp", 8'h50, 16'h0000, 64'h1, 1'b0, 5, 1'b0);
    applyStimulus("badcmd", 8'h90, 16'h0102, 64'h0304_0506, 1'b0, 0, 1'b0);
    applyStimulus("csr_after", 8'h00, 16'h0008, 64'h8, 1'b0, 0, 1'b0);
    checkOutput("badcmd_errcnt", 64'(obsErrCnt), 64'd1);
    timeoutCase("tmo", 1'b0);
    timeoutCase("tmo_rescue", 1'b1);

    sel = 1'b1;
    applyStimulus("buf1_w8", 8'h30, 16'h0001, 64'h100F_0E0D_0C0B_0A09, 1'b0, 0, 1'b0);
    applyStimulus("csum_bad", 8'h20, 16'hBEEF, 64'h0123_4567_89AB_CDEF, 1'b1, 0, 1'b0);
    applyStimulus("csum_good", 8'h20, 16'hBEEF, 64'h0123_4567_89AB_CDEF, 1'b0, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      sel = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: cmd = 8'h00;
        1: cmd = 8'h20;
        2: cmd = 8'h30;
        3: cmd = 8'h50;
        4: cmd = 8'h70;
        default: cmd = 8'($urandom_range(0, 255));
      endcase
      stb = modelStrobe(cmd);
      bad = sel && (stb != 5'd0) && ($urandom_range(0, 3) == 0);
      applyStimulus("rand", cmd, 16'($urandom), {32'($urandom), 32'($urandom)}, bad,
                    $urandom_range(0, 3), 1'b1);
    end

    sel = 1'b0;
    q = buildPacket(8'h70, 16'h00AA, 64'h1111, 1'b0);
    sendBytes(q, 1'b0);
    checkOutput("rstdisp_pre", 64'(obsStrobe), 64'b10000);
    pulseReset();
    checkOutput("rstdisp_stb", 64'(obsStrobe), 64'd0);
    checkOutput("rstdisp_busy", 64'(obsBusy), 64'd0);
    checkOutput("rstdisp_pkt", 64'(obsPkt), 64'd0);
    for (int i = 0; i < 3; i++) part.push_back(q[i]);
    sendBytes(part, 1'b0);
    checkOutput("rstpkt_pre", 64'(obsBusy), 64'd1);
    pulseReset();
    checkOutput("rstpkt_busy", 64'(obsBusy), 64'd0);
    checkOutput("rstpkt_stb", 64'(obsStrobe), 64'd0);
    applyStimulus("recover", 8'h20, 16'h4321, 64'hDEAD_BEEF, 1'b0, 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_cmd_decoder.md
PKT_CMD_DECODER -- requirements
Module: pkt_cmd_decoder

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4, meaning payload bytes per packet (legal 1..8).
REQ-002 SHALL have parameter ADDR_BYTES, default 2, meaning address bytes per packet (legal 1..4).
REQ-003 SHALL have parameter NUM_BUF, default 2, meaning number of buffer-write channels (legal 1..8).
REQ-004 SHALL have parameter CSUM_EN, default 0, meaning an XOR checksum byte trails each packet when 1.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 50000, meaning the maximum idle clocks between bytes within one packet.
REQ-006 SHALL have one clock and a synchronous, active-high reset: clk input 1 (system clock); rst input 1 (synchronous active-high reset).
REQ-007 SHALL have in_valid input 1 (byte strobe from UART RX), in_data input 8 (byte), in_ready output 1 (byte accepted when in_valid and in_ready).
REQ-008 SHALL have dsp_ready input 1, meaning the sink accepts the current dispatch.
REQ-009 SHALL have csr_we output 1, buf_we output NUM_BUF, start_pulse output 1, status_req output 1 (dispatch strobes); addr output 8*ADDR_BYTES; wdata output 8*DATA_BYTES.
REQ-010 SHALL have busy output 1 (mid-packet), err_pulse output 1, err_code output 2, pkt_cnt output 16, err_cnt output 8.

Function
REQ-011 Packet framing SHALL be: cmd byte, ADDR_BYTES address bytes, DATA_BYTES data bytes, then one checksum byte if CSUM_EN; multi-byte fields are little-endian.
REQ-012 Command decode SHALL be: 0x00 CSR write; 0x20+0x10*c, for c < NUM_BUF, buffer-c write; 0x50 start; 0x70 status request; any other value is illegal.
REQ-013 The FSM SHALL have states S_CMD, S_ADDR, S_DATA, S_CSUM and S_DISP, with transitions S_CMD->S_ADDR->S_DATA->(S_CSUM if CSUM_EN)->S_DISP->S_CMD.
REQ-014 A byte counter SHALL advance per accepted byte and clear on each state change.
REQ-015 in_ready SHALL be 1 in every state except S_DISP.
REQ-016 busy SHALL be 1 in every state except S_CMD.
REQ-017 In S_DISP exactly one strobe SHALL assert, addr/wdata SHALL be held stable, and the strobe SHALL remain asserted until the cycle dsp_ready=1; the FSM SHALL return to S_CMD on the next edge.
REQ-018 When dsp_ready=1 on the first S_DISP cycle, dispatch latency SHALL be 1 clock after the last byte is accepted.
REQ-019 With CSUM_EN, the XOR of all packet bytes including the checksum SHALL equal 0x00; otherwise the packet SHALL not be dispatched, err_code SHALL be 2'd2 and err_pulse SHALL fire.
REQ-020 An illegal cmd SHALL still consume the full packet length, with no dispatch, err_code 2'd1 and err_pulse.
REQ-021 A timeout counter SHALL clear on every accepted byte.
REQ-022 In S_ADDR, S_DATA or S_CSUM, when the timeout counter reaches TIMEOUT_CYC: the partial packet SHALL be discarded, err_code SHALL be 2'd3, err_pulse SHALL fire, and the FSM SHALL go to S_CMD.
REQ-023 A byte accepted in the same cycle that timeout would expire SHALL win, and no timeout SHALL occur.
REQ-024 err_pulse SHALL be a one-cycle pulse; err_code SHALL hold the last error code until the next error.
REQ-025 pkt_cnt SHALL increment on each completed dispatch and wrap at 0xFFFF.
REQ-026 err_cnt SHALL increment on each err_pulse and saturate at 0xFF.
REQ-027 No strobe SHALL assert outside S_DISP.

Reset
REQ-028 On rst, state SHALL be S_CMD and counters, addr, wdata, strobes, busy, err_pulse, err_code, pkt_cnt and err_cnt SHALL all be 0, with in_ready=1 the cycle after reset.
REQ-029 A reset mid-packet or mid-dispatch SHALL discard the packet, with no strobe on the following cycle.

Structure
REQ-030 A shared package pkt_pkg SHALL hold the command byte constants, the err_code enum (NONE=0, BADCMD=1, CSUM=2, TIMEOUT=3) and the state typedef.
REQ-031 One sub-module, pkt_timeout_ctr (clear/enable/expire counter sized by $clog2(TIMEOUT_CYC+1)), SHALL be instantiated.

Verification
REQ-032 CSR write: bytes 00 08 00 08 00 00 00 with dsp_ready=1 -> csr_we for 1 cycle, addr=0x0008, wdata=0x00000008, pkt_cnt=1.
REQ-033 Buffer write, DATA_BYTES=8, NUM_BUF=2: cmd 0x30, addr 0x0001, data bytes 09..10 -> buf_we=2'b10, wdata=0x100F0E0D0C0B0A09.
REQ-034 Backpressure: start packet 50 00 00 01 00 00 00 with dsp_ready=0 for 5 cycles -> start_pulse held 6 cycles, in_ready=0 throughout, single dispatch.
REQ-035 Illegal cmd 0x90, then valid CSR packet -> err_code=1 with err_pulse and no strobe, then the CSR dispatch occurs correctly, err_cnt=1.
REQ-036 CSUM_EN=1, bad checksum byte -> no dispatch, err_code=2; then correct packet -> dispatched.
REQ-037 Timeout: TIMEOUT_CYC=100, stop after 3 bytes -> err_pulse exactly 100 cycles after the last byte, err_code=3, busy=0; same case with a byte at cycle 100 -> no error.
